// File: rtl/delay_cal_ctrl.sv
// Calibration controller for a programmable tap delay line: measures marker
// skew NMEAS times, removes the line's fixed latency and writes the tap once.
module delay_cal_ctrl #(
   parameter int MAX_DLY = 20,
   parameter int OFFSET  = 2,
   parameter int NMEAS   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       mark_fast,
   input  logic       mark_ref,
   output logic       wr_comm,
   output logic [7:0] upr,
   output logic [7:0] skew,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [1:0] err_code
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_FAST,
      S_COUNT,
      S_CHECK,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [7:0] TO     = 8'(TIMEOUT);
   localparam logic [7:0] OFF    = 8'(OFFSET);
   localparam logic [7:0] MAXTAP = 8'(MAX_DLY - 1);
   localparam logic [3:0] NM     = 4'(NMEAS);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] meas_idx_q, meas_idx_d;
   logic [7:0] ref_skew_q, ref_skew_d;
   logic [7:0] skew_m_q, skew_m_d;
   logic [7:0] skew_q, skew_d;
   logic [7:0] upr_q, upr_d;
   logic       wr_comm_q, wr_comm_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic [1:0] err_code_q, err_code_d;
   logic [3:0] meas_next;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      meas_idx_d = meas_idx_q;
      ref_skew_d = ref_skew_q;
      skew_m_d   = skew_m_q;
      skew_d     = skew_q;
      upr_d      = upr_q;
      wr_comm_d  = 1'b0;
      busy_d     = busy_q;
      done_d     = done_q;
      err_d      = err_q;
      err_code_d = err_code_q;
      meas_next  = meas_idx_q + 4'd1;
      unique case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               done_d     = 1'b0;
               err_d      = 1'b0;
               err_code_d = 2'd0;
               meas_idx_d = 4'd0;
               cnt_d      = 8'd0;
               busy_d     = 1'b1;
               state_d    = S_WAIT_FAST;
            end
         end
         S_WAIT_FAST: begin
            if (mark_fast && mark_ref) begin
               skew_m_d = 8'd0;
               state_d  = S_CHECK;
            end else if (mark_fast) begin
               cnt_d   = 8'd1;
               state_d = S_COUNT;
            end else if (cnt_q >= TO - 8'd1) begin
               cnt_d      = TO;
               err_d      = 1'b1;
               err_code_d = 2'd1;
               busy_d     = 1'b0;
               state_d    = S_ERR;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_COUNT: begin
            if (mark_ref) begin
               skew_m_d = cnt_q;
               state_d  = S_CHECK;
            end else if (cnt_q >= TO) begin
               err_d      = 1'b1;
               err_code_d = 2'd1;
               busy_d     = 1'b0;
               state_d    = S_ERR;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_CHECK: begin
            if (meas_idx_q != 4'd0 && skew_m_q != ref_skew_q) begin
               err_d      = 1'b1;
               err_code_d = 2'd2;
               busy_d     = 1'b0;
               state_d    = S_ERR;
            end else begin
               if (meas_idx_q == 4'd0) ref_skew_d = skew_m_q;
               meas_idx_d = meas_next;
               skew_d     = skew_m_q;
               if (meas_next < NM) begin
                  cnt_d   = 8'd0;
                  state_d = S_WAIT_FAST;
               end else if (skew_m_q < OFF || skew_m_q - OFF > MAXTAP) begin
                  err_d      = 1'b1;
                  err_code_d = 2'd3;
                  busy_d     = 1'b0;
                  state_d    = S_ERR;
               end else begin
                  // tap and strobe land together in the WRITE cycle
                  upr_d     = skew_m_q - OFF;
                  wr_comm_d = 1'b1;
                  state_d   = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 8'd0;
         meas_idx_q <= 4'd0;
         ref_skew_q <= 8'd0;
         skew_m_q   <= 8'd0;
         skew_q     <= 8'd0;
         upr_q      <= 8'd0;
         wr_comm_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= 2'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         meas_idx_q <= meas_idx_d;
         ref_skew_q <= ref_skew_d;
         skew_m_q   <= skew_m_d;
         skew_q     <= skew_d;
         upr_q      <= upr_d;
         wr_comm_q  <= wr_comm_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
      end
   end

   assign wr_comm  = wr_comm_q;
   assign upr      = upr_q;
   assign skew     = skew_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign err_code = err_code_q;

endmodule

// File: tb/tb_delay_cal_ctrl.sv
// Bench for delay_cal_ctrl: two instances (OFFSET=2 and OFFSET=0) share
// stimulus; outcomes come from a list-level model of the calibration rules.
module tb_delay_cal_ctrl;

   localparam int NMEAS = 4;
   localparam int MAXD  = 20;

   logic       clk = 1'b0;
   logic       rst, start, mark_fast, mark_ref;
   logic       wr [2];
   logic [7:0] upr [2];
   logic [7:0] skew [2];
   logic       busy [2];
   logic       done [2];
   logic       err [2];
   logic [1:0] code [2];

   int wc [2] = '{0, 0};
   int exp_upr [2];
   int offs [2];
   int n_chk, n_err;
   int q [$];

   delay_cal_ctrl #(.MAX_DLY(20), .OFFSET(2), .NMEAS(4), .TIMEOUT(255)) u0 (
      .clk(clk), .rst(rst), .start(start),
      .mark_fast(mark_fast), .mark_ref(mark_ref),
      .wr_comm(wr[0]), .upr(upr[0]), .skew(skew[0]),
      .busy(busy[0]), .done(done[0]), .err(err[0]),
      .err_code(code[0])
   );

   delay_cal_ctrl #(.MAX_DLY(20), .OFFSET(0), .NMEAS(4), .TIMEOUT(255)) u1 (
      .clk(clk), .rst(rst), .start(start),
      .mark_fast(mark_fast), .mark_ref(mark_ref),
      .wr_comm(wr[1]), .upr(upr[1]), .skew(skew[1]),
      .busy(busy[1]), .done(done[1]), .err(err[1]),
      .err_code(code[1])
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++)
         if (wr[i] === 1'b1) wc[i] <= wc[i] + 1;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_st(input int i, input string tag, input bit b,
                         input bit d, input bit e, input int c);
      string p;
      p = $sformatf("%s.d%0d", tag, i);
      chk({p, ".busy"}, 32'(busy[i]), 32'(b));
      chk({p, ".done"}, 32'(done[i]), 32'(d));
      chk({p, ".err"}, 32'(err[i]), 32'(e));
      chk({p, ".err_code"}, 32'(code[i]), c);
      chk({p, ".upr"}, 32'(upr[i]), exp_upr[i]);
   endtask

   task automatic chk_zero(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk_st(i, tag, 0, 0, 0, 0);
         chk($sformatf("%s.d%0d.wr", tag, i), 32'(wr[i]), 0);
         chk($sformatf("%s.d%0d.skew", tag, i), 32'(skew[i]), 0);
      end
   endtask

   // one marker pair: mark_ref d cycles after mark_fast
   task automatic meas(input int d, input bit st);
      mark_fast = 1'b1;
      mark_ref  = (d == 0);
      start     = st;
      tick;
      mark_fast = 1'b0;
      mark_ref  = 1'b0;
      start     = 1'b0;
      if (d > 0) begin
         repeat (d - 1) tick;
         mark_ref = 1'b1;
         tick;
         mark_ref = 1'b0;
      end
   endtask

   function automatic int first_mis();
      for (int i = 1; i < q.size(); i++)
         if (q[i] != q[0]) return i;
      return NMEAS;
   endfunction

   task automatic rep(input int s);
      q = {};
      repeat (NMEAS) q.push_back(s);
   endtask

   task automatic run_cal(input string tag);
      int  k, last, s;
      int  w0 [2];
      bit  ok [2];
      w0[0] = wc[0];
      w0[1] = wc[1];
      start = 1'b1;
      tick;
      start = 1'b0;
      for (int i = 0; i < 2; i++) chk_st(i, {tag, ".start"}, 1, 0, 0, 0);
      k    = first_mis();
      last = (k < NMEAS) ? k : NMEAS - 1;
      for (int j = 0; j <= last; j++) begin
         repeat ($urandom_range(0, 2)) begin
            start = ($urandom_range(0, 1) == 1);
            tick;
            start = 1'b0;
         end
         meas(q[j], $urandom_range(0, 3) == 0);
         tick;
         if (j < last)
            for (int i = 0; i < 2; i++)
               chk($sformatf("%s.m%0d.d%0d.skew", tag, j, i),
                   32'(skew[i]), q[j]);
      end
      s = q[0];
      for (int i = 0; i < 2; i++)
         ok[i] = (k >= NMEAS) && (s >= offs[i]) && (s - offs[i] <= MAXD - 1);
      for (int i = 0; i < 2; i++) begin
         if (ok[i]) begin
            chk($sformatf("%s.d%0d.wr", tag, i), 32'(wr[i]), 1);
            chk($sformatf("%s.d%0d.upr_w", tag, i), 32'(upr[i]), s - offs[i]);
            chk($sformatf("%s.d%0d.skew", tag, i), 32'(skew[i]), s);
            chk($sformatf("%s.d%0d.busy_w", tag, i), 32'(busy[i]), 1);
         end else begin
            chk($sformatf("%s.d%0d.wr", tag, i), 32'(wr[i]), 0);
            chk_st(i, {tag, ".abort"}, 0, 0, 1, (k < NMEAS) ? 2 : 3);
         end
      end
      tick;
      for (int i = 0; i < 2; i++) begin
         if (ok[i]) begin
            exp_upr[i] = s - offs[i];
            chk_st(i, {tag, ".end"}, 0, 1, 0, 0);
         end else begin
            chk_st(i, {tag, ".end"}, 0, 0, 1, (k < NMEAS) ? 2 : 3);
         end
         chk($sformatf("%s.d%0d.wr_end", tag, i), 32'(wr[i]), 0);
         chk($sformatf("%s.d%0d.pulses", tag, i), wc[i] - w0[i], 32'(ok[i]));
      end
   endtask

   task automatic wait_timeout(input string tag);
      int n;
      n = 0;
      repeat (250) tick;
      for (int i = 0; i < 2; i++) chk_st(i, {tag, ".early"}, 1, 0, 0, 0);
      while (err[0] !== 1'b1 && n < 40) begin
         tick;
         n++;
      end
      for (int i = 0; i < 2; i++) chk_st(i, tag, 0, 0, 1, 1);
   endtask

   initial begin
      int w0 [2];
      offs[0]    = 2;
      offs[1]    = 0;
      exp_upr[0] = 0;
      exp_upr[1] = 0;
      n_chk      = 0;
      n_err      = 0;
      rst        = 1'b1;
      start      = 1'b0;
      mark_fast  = 1'b0;
      mark_ref   = 1'b0;
      repeat (2) tick;
      chk_zero("reset");
      rst = 1'b0;
      tick;
      chk_zero("idle");

      rep(7);
      run_cal("skew7");
      q = {};
      q.push_back(7);
      q.push_back(7);
      q.push_back(8);
      run_cal("mismatch");
      rep(1);
      run_cal("skew1");
      rep(22);
      run_cal("skew22");
      rep(21);
      run_cal("skew21");
      rep(2);
      run_cal("skew2");

      w0[0] = wc[0];
      w0[1] = wc[1];
      start = 1'b1;
      tick;
      start = 1'b0;
      wait_timeout("to_fast");
      start = 1'b1;
      tick;
      start = 1'b0;
      mark_fast = 1'b1;
      tick;
      mark_fast = 1'b0;
      wait_timeout("to_ref");
      for (int i = 0; i < 2; i++)
         chk($sformatf("to.d%0d.pulses", i), wc[i] - w0[i], 0);

      start = 1'b1;
      tick;
      start = 1'b0;
      mark_fast = 1'b1;
      tick;
      mark_fast = 1'b0;
      repeat (3) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      exp_upr[0] = 0;
      exp_upr[1] = 0;
      chk_zero("rst_mid");
      repeat (3) tick;
      chk_zero("rst_idle");
      rep(5);
      run_cal("skew5");
      rep(0);
      run_cal("skew0");

      for (int r = 0; r < 20; r++) begin
         int s;
         s = $urandom_range(0, 25);
         rep(s);
         if ($urandom_range(0, 3) == 0)
            q[$urandom_range(1, 3)] = s + 1 + $urandom_range(0, 3);
         run_cal($sformatf("rnd%0d", r));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
